// File: rtl/fpu_pkg.sv
// Shared types for the bf16 add/sub arbiter: operand type, canonical quiet NaN,
// arbiter FSM states and the operand sign-flip helper used to turn A-B into A+(-B).
`timescale 1ns/1ps
package fpu_pkg;
  typedef logic [15:0] bf16_t;
  localparam bf16_t BF16_QNAN = 16'h7FC0;

  typedef enum logic [1:0] {ARB_IDLE, ARB_EXEC, ARB_EXEC2, ARB_RESP} arb_state_e;

  function automatic bf16_t bf16_apply_sub(input bf16_t b, input logic sub);
    return {b[15] ^ sub, b[14:0]};
  endfunction
endpackage

// File: rtl/Add_Sub.sv
// Combinational bf16 adder: round-to-nearest-even, subnormals flushed to zero,
// NaN results canonicalised to BF16_QNAN. Subtraction is done by the caller flipping B's sign.
`timescale 1ns/1ps
module Add_Sub
  import fpu_pkg::*;
(
  input  bf16_t i_a,
  input  bf16_t i_b,
  output bf16_t o_c
);
  logic w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  bf16_t w_big, w_small;
  logic [7:0]  w_shift;
  logic [15:0] w_mb, w_ms, w_ms_sh, w_norm;
  logic [16:0] w_sum;
  logic        w_sticky, w_eff_sub, w_up;
  logic signed [9:0] w_exp;
  logic [8:0]  w_man;
  logic [6:0]  w_frac;

  assign w_a_nan = (i_a[14:7] == 8'hFF) && (i_a[6:0] != 7'h0);
  assign w_b_nan = (i_b[14:7] == 8'hFF) && (i_b[6:0] != 7'h0);
  assign w_a_inf = (i_a[14:7] == 8'hFF) && (i_a[6:0] == 7'h0);
  assign w_b_inf = (i_b[14:7] == 8'hFF) && (i_b[6:0] == 7'h0);

  always_comb begin
    w_big   = i_a;
    w_small = i_b;
    if (i_b[14:0] > i_a[14:0]) begin
      w_big   = i_b;
      w_small = i_a;
    end
    w_mb    = (w_big[14:7]   != 8'h0) ? {1'b1, w_big[6:0],   8'h00} : 16'h0;
    w_ms    = (w_small[14:7] != 8'h0) ? {1'b1, w_small[6:0], 8'h00} : 16'h0;
    w_shift = w_big[14:7] - w_small[14:7];
    if (w_shift >= 8'd16) begin
      w_ms_sh  = 16'h0;
      w_sticky = |w_ms;
    end else begin
      w_ms_sh  = w_ms >> w_shift;
      w_sticky = |(w_ms & ((16'h1 << w_shift) - 16'h1));
    end
    // Bits shifted out of the smaller operand survive as a sticky LSB for rounding.
    w_ms_sh[0] = w_ms_sh[0] | w_sticky;
    w_eff_sub  = w_big[15] ^ w_small[15];
    w_sum = w_eff_sub ? ({1'b0, w_mb} - {1'b0, w_ms_sh}) : ({1'b0, w_mb} + {1'b0, w_ms_sh});
    w_exp = {2'b00, w_big[14:7]};
    if (w_sum[16]) begin
      w_norm = {w_sum[16:2], w_sum[1] | w_sum[0]};
      w_exp  = w_exp + 10'sd1;
    end else begin
      w_norm = w_sum[15:0];
    end
    for (int k = 0; k < 15; k++) begin
      if (!w_norm[15] && (w_norm != 16'h0)) begin
        w_norm = w_norm << 1;
        w_exp  = w_exp - 10'sd1;
      end
    end
    w_up  = w_norm[7] & (w_norm[8] | (|w_norm[6:0]));
    w_man = {1'b0, w_norm[15:8]} + {8'h00, w_up};
    if (w_man[8]) begin
      w_exp  = w_exp + 10'sd1;
      w_frac = 7'h0;
    end else begin
      w_frac = w_man[6:0];
    end

    // A normalised non-zero sum always has its hidden bit in w_man[8:7].
    if (!(w_man[8] | w_man[7]))  o_c = w_eff_sub ? 16'h0000 : {w_big[15], 15'h0};
    else if (w_exp >= 10'sd255)  o_c = {w_big[15], 8'hFF, 7'h0};
    else if (w_exp <= 10'sd0)    o_c = {w_big[15], 15'h0};
    else                         o_c = {w_big[15], w_exp[7:0], w_frac};

    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (i_a[15] != i_b[15]))) o_c = BF16_QNAN;
    else if (w_a_inf) o_c = i_a;
    else if (w_b_inf) o_c = i_b;
  end
endmodule

// File: rtl/fpu_rr_arb.sv
// Combinational round-robin pick: lowest set request at or above i_ptr, wrapping.
`timescale 1ns/1ps
module fpu_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);
  logic [NUM_REQ-1:0] w_rot;
  logic [IDX_W-1:0]   w_off;
  logic [IDX_W:0]     w_sum;

  // Rotate so the pointer position lands at bit 0, then take the lowest set bit.
  assign w_rot = NUM_REQ'({i_req, i_req} >> i_ptr);

  always_comb begin
    w_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = IDX_W'(k);
    end
  end

  assign w_sum   = {1'b0, i_ptr} + {1'b0, w_off};
  assign o_idx   = (w_sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(w_sum - (IDX_W+1)'(NUM_REQ))
                                                  : w_sum[IDX_W-1:0];
  assign o_any   = |i_req;
  assign o_grant = o_any ? (NUM_REQ'(1) << o_idx) : '0;
endmodule

// File: rtl/fpu_addsub_arbiter.sv
// Round-robin sharing of one bf16 Add_Sub among NUM_REQ requesters, one op in flight.
// Define FPU_ARB_PIPE_EN to register the adder output in an extra stage (latency 3 instead of 2).
`timescale 1ns/1ps
module fpu_addsub_arbiter
  import fpu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  input  logic [NUM_REQ*16-1:0] req_a_i,
  input  logic [NUM_REQ*16-1:0] req_b_i,
  input  logic [NUM_REQ-1:0]    req_sub_i,
  output logic [NUM_REQ-1:0]    rsp_valid_o,
  input  logic [NUM_REQ-1:0]    rsp_ready_i,
  output bf16_t                 rsp_result_o,
  output logic                  busy_o
);
  arb_state_e         r_state;
  logic [IDX_W-1:0]   r_rr_ptr, r_owner;
  bf16_t              r_a, r_b, r_result;
  logic [NUM_REQ-1:0] r_rsp_valid;
`ifdef FPU_ARB_PIPE_EN
  bf16_t              r_stage;
`endif

  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  bf16_t              w_sel_a, w_sel_b, w_c;

  fpu_rr_arb #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .i_req   (req_valid_i),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  Add_Sub u_add_sub (.i_a(r_a), .i_b(r_b), .o_c(w_c));

  assign w_sel_a      = req_a_i[16*w_idx +: 16];
  assign w_sel_b      = req_b_i[16*w_idx +: 16];
  // Ready is only offered from IDLE, so valid&&ready is exactly the grant.
  assign req_ready_o  = ((r_state == ARB_IDLE) && !rst_i) ? w_grant : '0;
  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_result_o = r_result;
  assign busy_o       = (r_state != ARB_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ARB_IDLE;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_result    <= '0;
      r_rsp_valid <= '0;
`ifdef FPU_ARB_PIPE_EN
      r_stage     <= '0;
`endif
    end else begin
      case (r_state)
        ARB_IDLE: if (w_any) begin
          r_a      <= w_sel_a;
          r_b      <= bf16_apply_sub(w_sel_b, req_sub_i[w_idx]);
          r_owner  <= w_idx;
          r_rr_ptr <= (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
          r_state  <= ARB_EXEC;
        end
`ifdef FPU_ARB_PIPE_EN
        ARB_EXEC: begin
          r_stage <= w_c;
          r_state <= ARB_EXEC2;
        end
        ARB_EXEC2: begin
          r_result    <= r_stage;
          r_rsp_valid <= NUM_REQ'(1) << r_owner;
          r_state     <= ARB_RESP;
        end
`else
        ARB_EXEC: begin
          r_result    <= w_c;
          r_rsp_valid <= NUM_REQ'(1) << r_owner;
          r_state     <= ARB_RESP;
        end
        ARB_EXEC2: r_state <= ARB_IDLE;
`endif
        ARB_RESP: if (rsp_ready_i[r_owner]) begin
          r_rsp_valid <= '0;
          r_state     <= ARB_IDLE;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// Bench for fpu_addsub_arbiter: real-arithmetic reference model checked every cycle,
// plus directed transactions with literal expected results, grant order and latency.
`timescale 1ns/1ps
module tb_fpu_addsub_arbiter;
`ifdef FPU_ARB_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_ready, req_sub, rsp_valid, rsp_ready;
  logic [63:0] req_a, req_b;
  logic [15:0] rsp_result;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  int grant_log[$];
  logic [15:0] rsp_log[$];

  always #5 clk = ~clk;

  fpu_addsub_arbiter dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b), .req_sub_i(req_sub), .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result), .busy_o(busy)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  // ---------------- reference model (real arithmetic) ----------------
  function automatic real b2r(input logic [15:0] x);
    logic [63:0] bits;
    if (x[14:7] == 8'h0) return 0.0;
    bits = {x[15], 11'(int'(x[14:7]) - 127 + 1023), x[6:0], 45'd0};
    return $bitstoreal(bits);
  endfunction

  function automatic logic [15:0] r2b(input real r);
    logic [63:0] bits;
    int e;
    logic [7:0] m;
    logic up;
    bits = $realtobits(r);
    e  = int'(bits[62:52]) - 1023 + 127;
    up = bits[44] && (bits[45] || (bits[43:0] != 44'd0));
    m  = {1'b0, bits[51:45]} + {7'd0, up};
    if (m[7]) begin e++; m = 8'd0; end
    if (e >= 255) return {bits[63], 8'hFF, 7'h0};
    if (e <= 0)   return {bits[63], 15'h0};
    return {bits[63], 8'(e), m[6:0]};
  endfunction

  function automatic logic [15:0] fp_model(input logic [15:0] a, input logic [15:0] b, input logic sub);
    logic [15:0] be;
    real s;
    be = {b[15] ^ sub, b[14:0]};
    if ((a[14:7] == 8'hFF && a[6:0] != 0) || (be[14:7] == 8'hFF && be[6:0] != 0)) return 16'h7FC0;
    if (a[14:0] == 15'h7F80 && be[14:0] == 15'h7F80) return (a[15] != be[15]) ? 16'h7FC0 : a;
    if (a[14:0] == 15'h7F80) return a;
    if (be[14:0] == 15'h7F80) return be;
    s = b2r(a) + b2r(be);
    if (s == 0.0) return (a[15] && be[15]) ? 16'h8000 : 16'h0000;
    return r2b(s);
  endfunction

  function automatic int rr_pick(input logic [3:0] v, input int ptr);
    for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  // ---------------- per-cycle compare against the model ----------------
  int cyc = 0;
  bit mdl_on = 0, m_inflight = 0;
  int m_grant_cyc = 0, m_owner = 0, m_ptr = 0;
  logic [15:0] m_res = 16'h0, m_prev = 16'h0;

  always @(negedge clk) begin
    int idx;
    bit show;
    cyc++;
    if (rst) begin
      mdl_on = 1; m_inflight = 0; m_ptr = 0; m_prev = 16'h0;
    end else if (mdl_on) begin
      idx  = m_inflight ? -1 : rr_pick(req_valid, m_ptr);
      show = m_inflight && (cyc - m_grant_cyc >= LAT);
      chk("mdl_ready", req_ready, (idx >= 0) ? (32'd1 << idx) : 32'd0);
      chk("mdl_valid", rsp_valid, show ? (32'd1 << m_owner) : 32'd0);
      chk("mdl_result", rsp_result, show ? m_res : m_prev);
      chk("mdl_busy", busy, m_inflight);
      if (idx >= 0) begin
        m_inflight = 1; m_grant_cyc = cyc; m_owner = idx; m_ptr = (idx + 1) % N;
        m_res = fp_model(req_a[16*idx +: 16], req_b[16*idx +: 16], req_sub[idx]);
      end else if (show && rsp_ready[m_owner]) begin
        m_inflight = 0; m_prev = m_res;
      end
      for (int k = 0; k < N; k++) if (req_ready[k] && req_valid[k]) grant_log.push_back(k);
      if ((rsp_valid & rsp_ready) != 4'h0) rsp_log.push_back(rsp_result);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic reset_dut();
    step();
    rst = 1; req_valid = 0; rsp_ready = 0;
    step(); step();
    rst = 0;
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic sub);
    req_a[16*i +: 16] = a; req_b[16*i +: 16] = b; req_sub[i] = sub; req_valid[i] = 1'b1;
  endtask

  task automatic wait_rsp(output int lat, output int bc);
    lat = 0; bc = 0;
    do begin
      @(negedge clk); lat++; bc += int'(busy);
    end while (rsp_valid == 4'h0 && lat < 10);
  endtask

  task automatic do_op(input int idx, input logic [15:0] a, input logic [15:0] b, input logic sub,
                       input logic [15:0] exp, input int hold);
    int n, lat, bc;
    step();
    set_req(idx, a, b, sub);
    n = 0;
    @(negedge clk);
    while (!req_ready[idx] && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      chk("grant_timeout", req_ready, 32'd1 << idx);
      req_valid[idx] = 1'b0;
      return;
    end
    step();
    req_valid[idx] = 1'b0;
    wait_rsp(lat, bc);
    chk("latency", lat, LAT);
    chk("rsp_onehot", rsp_valid, 32'd1 << idx);
    chk("result", rsp_result, exp);
    repeat (hold) begin
      step(); @(negedge clk); bc += int'(busy);
      chk("hold_result", rsp_result, exp);
      chk("hold_ready", req_ready, 0);
    end
    step(); rsp_ready[idx] = 1'b1;
    @(negedge clk); bc += int'(busy);
    step(); rsp_ready[idx] = 1'b0;
    @(negedge clk);
    chk("busy_cycles", bc, LAT + 1 + hold);
    chk("idle_after", busy, 0);
  endtask

  initial begin
    int n, lat, bc;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    logic [15:0] exp_res[4] = '{16'h4000, 16'h4040, 16'h4000, 16'h4080};
    rst = 1; req_valid = 0; req_sub = 0; rsp_ready = 0; req_a = '0; req_b = '0;
    reset_dut();
    @(negedge clk);
    chk("rst_ready", req_ready, 0); chk("rst_valid", rsp_valid, 0);
    chk("rst_result", rsp_result, 0); chk("rst_busy", busy, 0);

    do_op(0, 16'h3F80, 16'h4000, 1'b0, 16'h4040, 0);   // 1 + 2 = 3
    do_op(2, 16'h4040, 16'h3F80, 1'b1, 16'h4000, 0);   // 3 - 1 = 2
    do_op(1, 16'h7F80, 16'h7F80, 1'b1, 16'h7FC0, 0);   // inf - inf
    do_op(1, 16'h3F80, 16'h3F80, 1'b1, 16'h0000, 1);   // 1 - 1
    do_op(3, 16'hC000, 16'h3F80, 1'b0, 16'hBF80, 0);   // -2 + 1
    do_op(0, 16'h3F80, 16'h3B80, 1'b0, 16'h3F80, 0);   // tie, rounds to even
    do_op(0, 16'h3F81, 16'h3B80, 1'b0, 16'h3F82, 0);   // tie, rounds up to even

    // All four continuously valid: grant order must rotate 0,1,2,3,0.
    reset_dut();
    grant_log.delete(); rsp_log.delete();
    set_req(0, 16'h3F80, 16'h3F80, 1'b0); set_req(1, 16'h4000, 16'h3F80, 1'b0);
    set_req(2, 16'h4040, 16'h3F80, 1'b1); set_req(3, 16'h4000, 16'h4000, 1'b0);
    rsp_ready = 4'hF;
    n = 0;
    while (grant_log.size() < 5 && n < 40) begin step(); n++; end
    req_valid = 4'h0;
    if (grant_log.size() < 5 || rsp_log.size() < 4) chk("rr_log_size", grant_log.size(), 5);
    else begin
      for (int k = 0; k < 5; k++) chk("rr_order", grant_log[k], exp_order[k]);
      for (int k = 0; k < 4; k++) chk("rr_result", rsp_log[k], exp_res[k]);
    end
    repeat (6) step();
    rsp_ready = 4'h0;

    // Owner withholds ready; non-owner ready ignored; waiting req1 granted right after.
    reset_dut();
    set_req(0, 16'h3F80, 16'h4000, 1'b0); set_req(1, 16'h4000, 16'h3F80, 1'b1);
    @(negedge clk);
    chk("s5_grant0", req_ready, 4'b0001);
    step(); req_valid[0] = 1'b0; rsp_ready = 4'b0010;
    wait_rsp(lat, bc);
    chk("s5_latency", lat, LAT);
    repeat (5) begin
      step(); @(negedge clk);
      chk("s5_hold_result", rsp_result, 16'h4040);
      chk("s5_hold_valid", rsp_valid, 4'b0001);
      chk("s5_hold_ready", req_ready, 0);
    end
    step(); rsp_ready = 4'b0001;
    @(negedge clk);
    chk("s5_hs_ready", req_ready, 0);
    step(); rsp_ready = 4'b0000;
    @(negedge clk);
    chk("s5_next_grant", req_ready, 4'b0010);
    step(); req_valid = 4'h0; rsp_ready = 4'hF;
    repeat (6) step();
    rsp_ready = 4'h0;

    // Reset while in RESP: everything clears, no response, pointer back to 0.
    reset_dut();
    set_req(2, 16'h3F80, 16'h3F80, 1'b0);
    @(negedge clk);
    chk("s6_grant2", req_ready, 4'b0100);
    step(); req_valid = 4'h0;
    wait_rsp(lat, bc);
    chk("s6_in_resp", rsp_valid, 4'b0100);
    step(); rst = 1;
    step(); rst = 0;
    @(negedge clk);
    chk("s6_ready", req_ready, 0); chk("s6_valid", rsp_valid, 0);
    chk("s6_result", rsp_result, 0); chk("s6_busy", busy, 0);
    repeat (3) begin step(); @(negedge clk); chk("s6_no_rsp", rsp_valid, 0); end
    step();
    set_req(1, 16'h4000, 16'h4000, 1'b0); set_req(3, 16'h3F80, 16'h4000, 1'b0);
    @(negedge clk);
    chk("s6_ptr_reset", req_ready, 4'b0010);
    step(); req_valid[1] = 1'b0;
    wait_rsp(lat, bc);
    chk("s6_result2", rsp_result, 16'h4080);
    step(); req_valid = 4'h0; rsp_ready = 4'hF;
    repeat (8) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end
endmodule
